// File: rtl/uart_host_pkg.sv
// ---------------------------------------------------------------------------
// uart_host_pkg
// Shared constants for the COREUART host sequencer (uart_host_ctrl) and its
// round-robin arbiter (uart_rr_arb).
//   - FSM state encoding: IDLE, WRITE, SETTLE, READ
//   - STROBE_OFF: inactive level of the active-low UART strobes
//   - rx_err bit indices: ERR_PAR (parity), ERR_FRM (framing)
// ---------------------------------------------------------------------------
package uart_host_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WRITE  = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;
    localparam state_t ST_READ   = 2'd3;

    localparam logic STROBE_OFF = 1'b1;

    localparam int ERR_PAR = 0;
    localparam int ERR_FRM = 1;

endpackage

// File: rtl/uart_rr_arb.sv
// ---------------------------------------------------------------------------
// uart_rr_arb
// Round-robin grant over NUM_REQ requesters. The grant goes to the first
// requester at or after the pointer (wrapping). When 'advance' is high the
// pointer moves to grant+1 (mod NUM_REQ). With NUM_REQ=1 the pointer is
// always 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-requester request bits
//   advance     the current grant is being taken this cycle
//   grant       one-hot grant (combinational)
//   any         at least one request present
// ---------------------------------------------------------------------------
module uart_rr_arb
    import uart_host_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    assign any = |req;

    // Scan offsets 0..NUM_REQ-1 from the pointer; first hit wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    // Wraps to 0 after the last requester; for NUM_REQ=1 this is always 0.
    always_comb begin
        if (int'(gidx) == NUM_REQ - 1) ptr_nxt = '0;
        else                           ptr_nxt = gidx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ptr <= '0;
        else if (advance && found) ptr <= ptr_nxt;
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// ---------------------------------------------------------------------------
// uart_host_ctrl
// Single-master sequencer for the COREUART parallel interface. Shares the
// transmit path round-robin between NUM_REQ byte requesters and drains
// received bytes into a one-entry valid/ready buffer with error flags.
// Optional feature macro: UART_HOST_CTRL_TIMEOUT_EN (adds a 16-bit TX
// watchdog and the tx_timeout output).
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   req_valid/req_data      requester bytes (byte i at [8i+7:8i])
//   req_ready               one-hot accept pulse
//   rx_valid/rx_ready       received-byte buffer handshake
//   rx_data, rx_err         byte and {framing, parity} flags
//   ovf_sticky, ovf_clr     sticky UART overflow flag and its clear
//   uart_*                  COREUART strobes, data and status
//   tx_timeout              (macro only) watchdog pulse
// ---------------------------------------------------------------------------
module uart_host_ctrl
    import uart_host_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int TXRDY_SETTLE = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [7:0]           rx_data,
    output logic [1:0]           rx_err,
    output logic                 ovf_sticky,
    input  logic                 ovf_clr,
    output logic                 uart_csn,
    output logic                 uart_wen,
    output logic                 uart_oen,
    output logic [7:0]           uart_data_in,
    input  logic [7:0]           uart_data_out,
    input  logic                 uart_txrdy,
    input  logic                 uart_rxrdy,
    input  logic                 uart_parity_err,
    input  logic                 uart_framing_err,
    input  logic                 uart_overflow
`ifdef UART_HOST_CTRL_TIMEOUT_EN
    ,
    output logic                 tx_timeout
`endif
);

    localparam int CW = (TXRDY_SETTLE > 1) ? $clog2(TXRDY_SETTLE) : 1;

    state_t               state;
    logic                 rd_hold;
    logic [CW-1:0]        settle_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic                 any_req;
    logic                 rx_go;
    logic                 tx_go;
    logic [7:0]           sel_byte;

    // RX has priority; a read needs room in the buffer, which includes the
    // case where the consumer empties it this very cycle. rd_hold masks the
    // first IDLE cycle after a read so a lagging RXRDY is not read twice.
    assign rx_go = (state == ST_IDLE) && !rd_hold && uart_rxrdy &&
                   (!rx_valid || rx_ready);
    assign tx_go = (state == ST_IDLE) && !rx_go && uart_txrdy && any_req;

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .req     (req_valid),
        .advance (tx_go),
        .grant   (grant),
        .any     (any_req)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) sel_byte = req_data[8*i +: 8];
    end

    // Sequencer. Strobes default to inactive every cycle, so each strobe
    // is exactly one cycle wide and WRITE/READ can never overlap.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            rd_hold      <= 1'b0;
            settle_cnt   <= '0;
            req_ready    <= '0;
            uart_csn     <= STROBE_OFF;
            uart_wen     <= STROBE_OFF;
            uart_oen     <= STROBE_OFF;
            uart_data_in <= '0;
        end else begin
            req_ready <= '0;
            uart_csn  <= STROBE_OFF;
            uart_wen  <= STROBE_OFF;
            uart_oen  <= STROBE_OFF;
            case (state)
                ST_IDLE: begin
                    rd_hold <= 1'b0;
                    if (rx_go) begin
                        state    <= ST_READ;
                        uart_csn <= ~STROBE_OFF;
                        uart_oen <= ~STROBE_OFF;
                    end else if (tx_go) begin
                        state        <= ST_WRITE;
                        req_ready    <= grant;
                        uart_data_in <= sel_byte;
                    end
                end
                // Accept pulse is visible now; launch the write strobe.
                ST_WRITE: begin
                    uart_csn   <= ~STROBE_OFF;
                    uart_wen   <= ~STROBE_OFF;
                    settle_cnt <= CW'(TXRDY_SETTLE - 1);
                    state      <= ST_SETTLE;
                end
                // TXRDY lags the write; ignore it for TXRDY_SETTLE cycles.
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_IDLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                ST_READ: begin
                    rd_hold <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture happens while OEN is low; capture beats a same-cycle pop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_err   <= '0;
        end else if (state == ST_READ) begin
            rx_valid        <= 1'b1;
            rx_data         <= uart_data_out;
            rx_err[ERR_FRM] <= uart_framing_err;
            rx_err[ERR_PAR] <= uart_parity_err;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Set beats clear so an overflow coinciding with the clear is kept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)           ovf_sticky <= 1'b0;
        else if (uart_overflow) ovf_sticky <= 1'b1;
        else if (ovf_clr)       ovf_sticky <= 1'b0;
    end

`ifdef UART_HOST_CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Counts IDLE cycles spent starved of TXRDY while someone is waiting.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wd_cnt     <= '0;
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= 1'b0;
            if (tx_go) begin
                wd_cnt <= '0;
            end else if (state == ST_IDLE && any_req && !uart_txrdy) begin
                if (wd_cnt == 16'hFFFF) begin
                    tx_timeout <= 1'b1;
                    wd_cnt     <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule
